// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand, result and handshake bundle between an issue slot and its alu_pipe.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic             alu_op;
    logic [4:0]       func;
    logic             i_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             neg;
    logic             busy;

    modport master (
        output in_valid, alu_in1, alu_in2, alu_op, func, i_carry, out_ready,
        input  in_ready, out_valid, alu_out, carry, overflow, zero, neg, busy
    );

    modport slave (
        input  in_valid, alu_in1, alu_in2, alu_op, func, i_carry, out_ready,
        output in_ready, out_valid, alu_out, carry, overflow, zero, neg, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU (add/sub/shr/not) with an iterative shift-add multiply behind valid/ready.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam logic [4:0] F_SUB = 5'b00101;
    localparam logic [4:0] F_SHR = 5'b01001;
    localparam logic [4:0] F_NOT = 5'b00110;
    localparam logic [4:0] F_MUL = 5'b01010;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d, mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vld_q, vld_d, c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
    logic [WIDTH:0]     add_r, sub_r, shr_r;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_v, accept;

    assign bus.in_ready  = rst_n && state_q == IDLE && (!vld_q || bus.out_ready);
    assign bus.busy      = state_q == MUL;
    assign bus.out_valid = vld_q;
    assign bus.alu_out   = out_q;
    assign bus.carry     = c_q;
    assign bus.overflow  = v_q;
    assign bus.zero      = z_q;
    assign bus.neg       = n_q;

    always_comb begin
        add_r = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
        sub_r = {1'b0, bus.alu_in2} - {1'b0, bus.alu_in1} - {{WIDTH{1'b0}}, bus.i_carry};
        // bit 0 of the widened shift is the last bit shifted out, 0 for in1=0 or in1>WIDTH
        shr_r = {bus.alu_in2, 1'b0} >> bus.alu_in1;
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        if (!bus.alu_op) begin
            res   = add_r[WIDTH-1:0];
            res_c = add_r[WIDTH];
            res_v = bus.alu_in1[WIDTH-1] == bus.alu_in2[WIDTH-1] && res[WIDTH-1] != bus.alu_in1[WIDTH-1];
        end else if (bus.func == F_SUB) begin
            res   = sub_r[WIDTH-1:0];
            res_c = sub_r[WIDTH];
            res_v = bus.alu_in1[WIDTH-1] != bus.alu_in2[WIDTH-1] && res[WIDTH-1] != bus.alu_in2[WIDTH-1];
        end else if (bus.func == F_SHR) begin
            res   = shr_r[WIDTH:1];
            res_c = shr_r[0];
        end else if (bus.func == F_NOT) begin
            res   = ~bus.alu_in2;
        end
    end

    always_comb begin
        accept   = bus.in_valid && bus.in_ready;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        state_d  = state_q;
        out_d    = out_q;
        c_d      = c_q;
        v_d      = v_q;
        z_d      = z_q;
        n_d      = n_q;
        vld_d    = vld_q && !bus.out_ready;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (accept && bus.alu_op && bus.func == F_MUL) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.alu_in1};
            mplier_d = bus.alu_in2;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = MUL;
        end else if (accept) begin
            out_d = res;
            c_d   = res_c;
            v_d   = res_v;
            z_d   = res == '0;
            n_d   = res[WIDTH-1];
            vld_d = 1'b1;
        end else if (state_q == MUL) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                out_d   = acc_sum[WIDTH-1:0];
                c_d     = 1'b0;
                v_d     = |acc_sum[2*WIDTH-1:WIDTH];
                z_d     = acc_sum[WIDTH-1:0] == '0;
                n_d     = acc_sum[WIDTH-1];
                vld_d   = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_q    <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            vld_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            c_q      <= c_d;
            v_q      <= v_d;
            z_q      <= z_d;
            n_q      <= n_d;
            vld_q    <= vld_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe; expected results queued at accept, compared at consume.
module tb_alu_pipe;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] out;
        logic         c, v, z, n;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    res_t sb[$];
    logic [4:0] fsel [6] = '{5'b00101, 5'b01001, 5'b00110, 5'b01010, 5'b00000, 5'b10110};

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                                   input logic [4:0] f, input logic ic);
        res_t r;
        logic [2*W-1:0] p;
        r = '0;
        if (!op) begin
            p     = 64'(a) + 64'(b);
            r.out = p[W-1:0];
            r.c   = p[W];
            r.v   = (a[W-1] == b[W-1]) && (r.out[W-1] != a[W-1]);
        end else begin
            case (f)
                5'b00101: begin
                    r.out = b - a - W'(ic);
                    r.c   = 33'(b) < 33'(a) + 33'(ic);
                    r.v   = (a[W-1] != b[W-1]) && (r.out[W-1] != b[W-1]);
                end
                5'b01001: begin
                    if (a == 0) r.out = b;
                    else if (a < W) begin
                        r.out = b >> a;
                        r.c   = b[a[4:0] - 5'd1];
                    end else if (a == W) r.c = b[W-1];
                end
                5'b00110: r.out = ~b;
                5'b01010: begin
                    p     = 64'(a) * 64'(b);
                    r.out = p[W-1:0];
                    r.v   = |p[2*W-1:W];
                end
                default: r = '0;
            endcase
        end
        r.z = r.out == 0;
        r.n = r.out[W-1];
        return r;
    endfunction

    function automatic res_t dut_res();
        return {bus.alu_out, bus.carry, bus.overflow, bus.zero, bus.neg};
    endfunction

    // Sampled on the falling edge, so both events describe what the next rising edge will do.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) chk("sb_result", dut_res(), sb.pop_front());
        end
        if (rst_n && bus.in_valid && bus.in_ready)
            sb.push_back(model(bus.alu_in1, bus.alu_in2, bus.alu_op, bus.func, bus.i_carry));
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         input logic [4:0] f, input logic ic);
        int k = 0;
        bus.alu_in1  = a;
        bus.alu_in2  = b;
        bus.alu_op   = op;
        bus.func     = f;
        bus.i_carry  = ic;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.in_ready && k < 200);
        if (k >= 200) chk("accept_timeout", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_now(input string tag, input res_t e);
        chk(tag, {bus.out_valid, dut_res()}, {1'b1, e});
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic [4:0]   f;
        logic         op;
        int           cyc;
        bus.in_valid  = 1'b0;
        bus.alu_in1   = '0;
        bus.alu_in2   = '0;
        bus.alu_op    = 1'b0;
        bus.func      = '0;
        bus.i_carry   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {bus.out_valid, bus.busy, dut_res()}, '0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'(1));

        issue(32'h7FFFFFFF, 32'h1, 1'b0, 5'b0, 1'b0);
        expect_now("add_ovf", {32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1});
        issue(32'hFFFFFFFF, 32'h1, 1'b0, 5'b0, 1'b0);
        expect_now("add_carry", {32'h0, 1'b1, 1'b0, 1'b1, 1'b0});
        issue(32'h1, 32'h1, 1'b1, 5'b00101, 1'b0);
        expect_now("sub_zero", {32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        issue(32'h2, 32'h1, 1'b1, 5'b00101, 1'b0);
        expect_now("sub_borrow", {32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1});
        issue(32'h1, 32'h80000000, 1'b1, 5'b00101, 1'b0);
        expect_now("sub_ovf", {32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0});
        issue(32'h1, 32'h80000001, 1'b1, 5'b01001, 1'b0);
        expect_now("shr_1", {32'h40000000, 1'b1, 1'b0, 1'b0, 1'b0});
        issue(32'h0, 32'h80000001, 1'b1, 5'b01001, 1'b0);
        expect_now("shr_0", {32'h80000001, 1'b0, 1'b0, 1'b0, 1'b1});
        issue(32'd40, 32'h80000001, 1'b1, 5'b01001, 1'b0);
        expect_now("shr_40", {32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        issue(32'd32, 32'h80000000, 1'b1, 5'b01001, 1'b0);
        expect_now("shr_32", {32'h0, 1'b1, 1'b0, 1'b1, 1'b0});
        issue(32'h0, 32'h0, 1'b1, 5'b00110, 1'b0);
        issue(32'h5, 32'h9, 1'b1, 5'b11111, 1'b1);

        issue(32'h10000, 32'h10000, 1'b1, 5'b01010, 1'b0);
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            chk("mul_busy", {bus.busy, bus.in_ready}, 2'b10);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("mul_latency", 64'(cyc), 64'(W));
        expect_now("mul_ovf", {32'h0, 1'b0, 1'b1, 1'b1, 1'b0});
        issue(32'd7, 32'd6, 1'b1, 5'b01010, 1'b0);
        wait_valid();
        expect_now("mul_7x6", {32'd42, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        issue(32'd2, 32'd3, 1'b0, 5'b0, 1'b0);
        bus.alu_in1  = 32'd1;
        bus.alu_in2  = 32'd10;
        bus.alu_op   = 1'b1;
        bus.func     = 5'b00101;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {bus.in_ready, bus.out_valid, dut_res()}, {1'b0, 1'b1, 32'd5, 4'b0000});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        expect_now("bp_sub", {32'd9, 1'b0, 1'b0, 1'b0, 1'b0});

        issue(32'd123, 32'd456, 1'b1, 5'b01010, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mul", {bus.out_valid, bus.busy, bus.in_ready, dut_res()}, '0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
        issue(32'd2, 32'd3, 1'b0, 5'b0, 1'b0);
        expect_now("post_rst_add", {32'd5, 1'b0, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 4) != 0;
            f  = fsel[$urandom_range(0, 5)];
            a  = (op && f == 5'b01001) ? W'($urandom_range(0, 40)) : W'($urandom);
            b  = $urandom;
            issue(a, b, op, f, 1'($urandom_range(0, 1)));
        end

        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
